// File: rtl/alu_deco_pipe.sv
// ALU control decoder with a valid/ready output register and a multicycle
// occupancy tracker for RV32M ops.
module alu_deco_pipe #(
    parameter int unsigned CTRL_W  = 5,
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              multicycle,
    output logic              busy,
    output logic              mc_done
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    localparam logic [CntW-1:0] MulInit = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivInit = CntW'(DIV_LAT - 1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    localparam logic [4:0] CodeAdd  = 5'd0;
    localparam logic [4:0] CodeSub  = 5'd1;
    localparam logic [4:0] CodeAnd  = 5'd2;
    localparam logic [4:0] CodeOr   = 5'd3;
    localparam logic [4:0] CodeXor  = 5'd4;
    localparam logic [4:0] CodeSll  = 5'd5;
    localparam logic [4:0] CodeSrl  = 5'd6;
    localparam logic [4:0] CodeSra  = 5'd7;
    localparam logic [4:0] CodeBeq  = 5'd8;
    localparam logic [4:0] CodeJal  = 5'd9;
    localparam logic [4:0] CodeSlt  = 5'd10;
    localparam logic [4:0] CodeSltu = 5'd11;
    localparam logic [4:0] CodeBne  = 5'd12;
    localparam logic [4:0] CodeBlt  = 5'd13;
    localparam logic [4:0] CodeBge  = 5'd14;
    localparam logic [4:0] CodeBltu = 5'd15;
    localparam logic [4:0] CodeBgeu = 5'd16;
    localparam logic [4:0] CodeMul  = 5'd17;
    localparam logic [4:0] CodeDiv  = 5'd21;

    typedef enum logic [1:0] {StIdle, StHold, StMcWait} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            div_q;

    logic [4:0] base_code;
    logic [4:0] dec_code;
    logic       dec_ok;
    logic       dec_mc;
    logic       dec_div;

    // Shared funct3 table for the base integer ops of I-type and R-type.
    always_comb begin
        base_code = CodeAdd;
        unique case (funct3)
            3'b000: base_code = CodeAdd;
            3'b001: base_code = CodeSll;
            3'b010: base_code = CodeSlt;
            3'b011: base_code = CodeSltu;
            3'b100: base_code = CodeXor;
            3'b101: base_code = CodeSrl;
            3'b110: base_code = CodeOr;
            3'b111: base_code = CodeAnd;
            default: base_code = CodeAdd;
        endcase
    end

    // Main decode; anything not matched falls out as illegal with code 0.
    always_comb begin
        dec_code = CodeAdd;
        dec_ok   = 1'b0;
        unique case (op)
            2'b00: dec_ok = (opcode == OpLoad) || (opcode == OpStore);
            2'b01: begin
                if (opcode == OpBranch) begin
                    dec_ok = 1'b1;
                    case (funct3)
                        3'b000:  dec_code = CodeBeq;
                        3'b001:  dec_code = CodeBne;
                        3'b100:  dec_code = CodeBlt;
                        3'b101:  dec_code = CodeBge;
                        3'b110:  dec_code = CodeBltu;
                        3'b111:  dec_code = CodeBgeu;
                        default: dec_ok   = 1'b0;
                    endcase
                end
            end
            2'b10: begin
                if (opcode == OpImm) begin
                    dec_code = base_code;
                    if (funct3 == 3'b001) begin
                        dec_ok = (funct7 == F7Base);
                    end else if (funct3 == 3'b101) begin
                        dec_ok = (funct7 == F7Base) || (funct7 == F7Alt);
                        if (funct7 == F7Alt) dec_code = CodeSra;
                    end else begin
                        dec_ok = 1'b1;
                    end
                end else if (opcode == OpReg) begin
                    if (funct7 == F7Base) begin
                        dec_code = base_code;
                        dec_ok   = 1'b1;
                    end else if (funct7 == F7Alt) begin
                        if (funct3 == 3'b000) begin
                            dec_code = CodeSub;
                            dec_ok   = 1'b1;
                        end else if (funct3 == 3'b101) begin
                            dec_code = CodeSra;
                            dec_ok   = 1'b1;
                        end
                    end else if ((funct7 == F7Mul) && EN_M) begin
                        dec_code = CodeMul + {2'b00, funct3};
                        dec_ok   = 1'b1;
                    end
                end
            end
            2'b11: begin
                if (opcode == OpJal) begin
                    dec_code = CodeJal;
                    dec_ok   = 1'b1;
                end else if ((opcode == OpJalr) && (funct3 == 3'b000)) begin
                    dec_ok = 1'b1;
                end
            end
            default: dec_ok = 1'b0;
        endcase
        if (!dec_ok) dec_code = CodeAdd;
    end

    assign dec_mc  = dec_ok && (dec_code >= CodeMul);
    assign dec_div = dec_ok && (dec_code >= CodeDiv);

    // A held multicycle result blocks the same-cycle refill so occupancy starts cleanly.
    assign in_ready = (state_q == StIdle) ||
                      ((state_q == StHold) && out_ready && !multicycle);

    // Handshake FSM with registered outputs and occupancy countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            out_valid  <= 1'b0;
            alu_ctrl   <= '0;
            illegal    <= 1'b0;
            multicycle <= 1'b0;
            busy       <= 1'b0;
            mc_done    <= 1'b0;
        end else begin
            mc_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q    <= StHold;
                        out_valid  <= 1'b1;
                        alu_ctrl   <= CTRL_W'(dec_code);
                        illegal    <= !dec_ok;
                        multicycle <= dec_mc;
                        div_q      <= dec_div;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        if (multicycle) begin
                            state_q   <= StMcWait;
                            out_valid <= 1'b0;
                            busy      <= 1'b1;
                            cnt_q     <= div_q ? DivInit : MulInit;
                            // A one-cycle occupancy finishes in its first cycle.
                            mc_done   <= ((div_q ? DivInit : MulInit) == '0);
                        end else if (in_valid) begin
                            alu_ctrl   <= CTRL_W'(dec_code);
                            illegal    <= !dec_ok;
                            multicycle <= dec_mc;
                            div_q      <= dec_div;
                        end else begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                        end
                    end
                end
                StMcWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CntW'(1);
                        mc_done <= (cnt_q == CntW'(1));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_deco_pipe.sv
// Directed plus randomized checks of alu_deco_pipe against a table-driven decode model.
module tb_alu_deco_pipe;

    localparam int unsigned MulLat = 3;
    localparam int unsigned DivLat = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [1:0] op;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] alu_ctrl;
    logic       illegal, multicycle, busy, mc_done;

    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [1:0] n_op;
    logic [6:0] n_opcode, n_funct7;
    logic [2:0] n_funct3;
    logic [4:0] n_alu_ctrl;
    logic       n_illegal, n_multicycle, n_busy, n_mc_done;

    int n_tests = 0;
    int n_fail  = 0;

    int alu_tab [8] = '{0, 5, 10, 11, 4, 6, 3, 2};
    int br_tab  [8] = '{8, 12, -1, -1, 13, 14, 15, 16};
    logic [6:0] opc_pool [7] = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h6f, 7'h67};
    logic [6:0] f7_pool  [3] = '{7'h00, 7'h20, 7'h01};

    alu_deco_pipe #(.CTRL_W(5), .EN_M(1'b1), .MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .multicycle(multicycle), .busy(busy), .mc_done(mc_done)
    );

    alu_deco_pipe #(.CTRL_W(5), .EN_M(1'b0), .MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
        .opcode(n_opcode), .funct3(n_funct3), .funct7(n_funct7), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .alu_ctrl(n_alu_ctrl), .illegal(n_illegal),
        .multicycle(n_multicycle), .busy(n_busy), .mc_done(n_mc_done)
    );

    // Expected ALU code, or -1 when the request has no legal decode.
    function automatic int ref_code(input logic [1:0] o, input logic [6:0] opc,
                                    input logic [2:0] f3, input logic [6:0] f7, input bit en_m);
        case (o)
            2'd0: return (opc == 7'h03 || opc == 7'h23) ? 0 : -1;
            2'd1: return (opc == 7'h63) ? br_tab[f3] : -1;
            2'd2: begin
                if (opc == 7'h13) begin
                    if (f3 == 3'd1) return (f7 == 7'h00) ? 5 : -1;
                    if (f3 == 3'd5) return (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 7 : -1;
                    return alu_tab[f3];
                end
                if (opc == 7'h33) begin
                    if (f7 == 7'h00) return alu_tab[f3];
                    if (f7 == 7'h20) return (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 7 : -1;
                    if (f7 == 7'h01 && en_m) return 17 + int'(f3);
                end
                return -1;
            end
            default: begin
                if (opc == 7'h6f) return 9;
                if (opc == 7'h67 && f3 == 3'd0) return 0;
                return -1;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One request through the EN_M=1 unit, stalled for 'hold' cycles before handshake.
    task automatic txn(input logic [1:0] o, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input int hold);
        int code;
        int lat;
        bit ill, mc;
        code = ref_code(o, opc, f3, f7, 1'b1);
        ill  = (code < 0);
        if (ill) code = 0;
        mc   = (code >= 17);
        lat  = (code >= 21) ? DivLat : MulLat;
        op = o; opcode = opc; funct3 = f3; funct7 = f7; in_valid = 1'b1; out_ready = 1'b0;
        #1 chk("idle_ready", in_ready, 1);
        step();
        for (int i = 0; i <= hold; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ctrl", alu_ctrl, code);
            chk("hold_illegal", illegal, ill);
            chk("hold_mc", multicycle, mc);
            if (i < hold) begin
                in_valid = 1'b1;
                op = 2'($urandom); opcode = 7'($urandom);
                funct3 = 3'($urandom); funct7 = 7'($urandom);
                #1 chk("stall_ready", in_ready, 0);
                step();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("hs_ready", in_ready, !mc);
        step();
        out_ready = 1'b0;
        if (mc) begin
            for (int k = 1; k <= lat; k++) begin
                chk("mc_busy", busy, 1);
                chk("mc_valid", out_valid, 0);
                chk("mc_ready", in_ready, 0);
                chk("mc_done", mc_done, (k == lat));
                step();
            end
        end
        chk("end_busy", busy, 0);
        chk("end_done", mc_done, 0);
        chk("end_valid", out_valid, 0);
        chk("end_ready", in_ready, 1);
    endtask

    // Single request through the EN_M=0 unit with out_ready held high.
    task automatic nm_txn(input logic [1:0] o, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7);
        int code;
        bit ill;
        code = ref_code(o, opc, f3, f7, 1'b0);
        ill  = (code < 0);
        if (ill) code = 0;
        n_op = o; n_opcode = opc; n_funct3 = f3; n_funct7 = f7;
        n_in_valid = 1'b1; n_out_ready = 1'b1;
        #1 chk("nm_ready", n_in_ready, 1);
        step();
        n_in_valid = 1'b0;
        chk("nm_valid", n_out_valid, 1);
        chk("nm_ctrl", n_alu_ctrl, code);
        chk("nm_illegal", n_illegal, ill);
        chk("nm_mc", n_multicycle, 0);
        step();
        chk("nm_idle_valid", n_out_valid, 0);
        chk("nm_busy", n_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; opcode = '0; funct3 = '0; funct7 = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b0;
        n_op = '0; n_opcode = '0; n_funct3 = '0; n_funct7 = '0;

        // Reset state
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mc", multicycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", mc_done, 0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", in_ready, 1);

        // SUB, one-cycle latency
        op = 2'b10; opcode = 7'h33; funct7 = 7'h20; funct3 = 3'b000;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sub_valid", out_valid, 1);
        chk("sub_ctrl", alu_ctrl, 1);
        chk("sub_illegal", illegal, 0);
        step();
        chk("sub_drain", out_valid, 0);

        // Back-to-back I-type ADD, SRA, SLTU
        op = 2'b10; opcode = 7'h13; funct7 = 7'h00; funct3 = 3'b000;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("b2b_add", alu_ctrl, 0);
        chk("b2b_v0", out_valid, 1);
        chk("b2b_r0", in_ready, 1);
        funct3 = 3'b101; funct7 = 7'h20;
        step();
        chk("b2b_sra", alu_ctrl, 7);
        chk("b2b_v1", out_valid, 1);
        chk("b2b_r1", in_ready, 1);
        funct3 = 3'b011; funct7 = 7'h00;
        step();
        chk("b2b_sltu", alu_ctrl, 11);
        chk("b2b_v2", out_valid, 1);
        chk("b2b_r2", in_ready, 1);
        in_valid = 1'b0;
        step();
        chk("b2b_drain", out_valid, 0);
        out_ready = 1'b0;

        // DIV occupancy, BNE stall, illegal request
        txn(2'b10, 7'h33, 3'b100, 7'h01, 0);
        txn(2'b01, 7'h63, 3'b001, 7'h00, 5);
        txn(2'b01, 7'h63, 3'b010, 7'h00, 1);
        txn(2'b10, 7'h33, 3'b000, 7'h01, 2);

        // Reset in the middle of a MUL occupancy
        op = 2'b10; opcode = 7'h33; funct3 = 3'b000; funct7 = 7'h01;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_ctrl", alu_ctrl, 17);
        chk("mrst_mc", multicycle, 1);
        step();
        out_ready = 1'b0;
        chk("mrst_busy0", busy, 1);
        step();
        chk("mrst_busy1", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_done", mc_done, 0);
        step();
        chk("mrst_done2", mc_done, 0);
        rst_n = 1'b1;
        step();
        chk("mrst_ready", in_ready, 1);
        chk("mrst_done3", mc_done, 0);
        chk("mrst_busy2", busy, 0);

        // EN_M=0: DIV is illegal
        nm_txn(2'b10, 7'h33, 3'b100, 7'h01);

        // Randomized requests on both units
        for (int n = 0; n < 60; n++) begin
            logic [1:0] ro;
            logic [6:0] ropc, rf7;
            logic [2:0] rf3;
            ro   = 2'($urandom_range(0, 3));
            ropc = ($urandom_range(0, 7) == 7) ? 7'($urandom) : opc_pool[$urandom_range(0, 6)];
            rf7  = ($urandom_range(0, 3) == 3) ? 7'($urandom) : f7_pool[$urandom_range(0, 2)];
            rf3  = 3'($urandom);
            txn(ro, ropc, rf3, rf7, int'($urandom_range(0, 2)));
            nm_txn(ro, ropc, rf3, rf7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_deco_pipe.md
ALU_DECO_PIPE -- requirements
Module: alu_deco_pipe

Interface
REQ-001 Parameter CTRL_W, default 5, alu_ctrl width; SHALL be >= 5.
REQ-002 Parameter EN_M, default 1, enables RV32M decode; 0 makes all M encodings illegal.
REQ-003 Parameter MUL_LAT, default 3, MUL-class occupancy cycles; SHALL be >= 1.
REQ-004 Parameter DIV_LAT, default 32, DIV/REM-class occupancy cycles; SHALL be >= 1.
REQ-005 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- op  in  2  main-decoder ALU op class
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7  in  7  full instruction funct7
- out_valid  out  1  registered result valid
- out_ready  in  1  consumer accepts result
- alu_ctrl  out  CTRL_W  ALU control code, zero-extended
- illegal  out  1  held request had no legal decode
- multicycle  out  1  held result is an M-extension op
- busy  out  1  multicycle unit occupancy in progress
- mc_done  out  1  one-cycle pulse at end of occupancy

Function
REQ-006 Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, BEQ 8, JAL 9, SLT 10, SLTU 11, BNE 12, BLT 13, BGE 14, BLTU 15, BGEU 16, MUL 17, MULH 18, MULHSU 19, MULHU 20, DIV 21, DIVU 22, REM 23, REMU 24.
REQ-007 op=00: opcode 0000011 or 0100011 -> ADD; else illegal.
REQ-008 op=01: opcode 1100011 required; funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU; 010, 011 or other opcode -> illegal.
REQ-009 op=10, opcode 0010011 (I-type): funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND (funct7 ignored); 001 SLL only if funct7=0000000; 101 SRL if funct7=0000000, SRA if 0100000; other funct7 on shifts -> illegal.
REQ-010 op=10, opcode 0110011 (R-type): funct7=0000000 -> funct3 000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL,110 OR,111 AND; funct7=0100000 -> 000 SUB, 101 SRA, others illegal; funct7=0000001 with EN_M=1 -> funct3 0..7 maps MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; any other funct7 illegal.
REQ-011 op=10 with any other opcode -> illegal.
REQ-012 op=11: opcode 1101111 -> JAL; 1100111 with funct3 000 -> ADD; else illegal.
REQ-013 Illegal decode SHALL set alu_ctrl=0, illegal=1, multicycle=0; never X.
REQ-014 FSM states IDLE, HOLD, MC_WAIT; decode registered on acceptance, latency 1 cycle from accept edge to out_valid.
REQ-015 in_ready = (IDLE) or (HOLD & out_ready & ~multicycle); 0 in MC_WAIT.
REQ-016 IDLE: accept -> HOLD.
REQ-017 HOLD: out_valid=1, outputs stable until out_ready; on out_ready: multicycle=1 -> MC_WAIT with counter=LAT-1 (MUL_LAT for MUL..MULHU, DIV_LAT for DIV..REMU); else new accept same cycle -> HOLD with new data (back-to-back, no bubble); else IDLE.
REQ-018 MC_WAIT: busy=1, out_valid=0, counter decrements each cycle; at counter=0 assert mc_done for that cycle and go IDLE; total MC_WAIT residence exactly LAT cycles.
REQ-019 Counter width SHALL be clog2(max(MUL_LAT,DIV_LAT)+1); no wrap possible.
REQ-020 Illegal requests SHALL flow through HOLD like legal single-cycle ops.
REQ-021 in_valid while in_ready=0 SHALL be ignored; requester holds inputs.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, counter 0, out_valid 0, alu_ctrl 0, illegal 0, multicycle 0, busy 0, mc_done 0; in_ready 1 after release.
REQ-023 Reset during HOLD or MC_WAIT SHALL discard held result and occupancy; no mc_done pulse.

Verification
REQ-024 op=10, opcode 0110011, funct7 0100000, funct3 000, out_ready=1 -> next cycle out_valid=1, alu_ctrl=1, illegal=0.
REQ-025 Three back-to-back I-type requests (ADD, SRA funct7 0100000, SLTU) with out_ready=1 -> alu_ctrl 0,7,11 on consecutive cycles, in_ready never drops.
REQ-026 R-type DIV (funct7 0000001, funct3 100), DIV_LAT=4 -> alu_ctrl=21, multicycle=1; after handshake busy=1 for 4 cycles, in_ready=0, mc_done on 4th, then in_ready=1.
REQ-027 EN_M=0, same DIV request -> illegal=1, alu_ctrl=0, multicycle=0, no busy.
REQ-028 out_ready=0 for 5 cycles with held BNE -> alu_ctrl=12 stable, in_ready=0; new in_valid ignored.
REQ-029 rst_n low 2 cycles into MUL occupancy -> immediate busy=0, out_valid=0, no mc_done; in_ready=1 after release.
